// File: rtl/bru_resolve_pipe_pkg.sv
// Shared definitions for the branch resolution unit: opcode encodings,
// default datapath width and the slot state encoding.
package bru_resolve_pipe_pkg;

`ifdef LA64
   localparam int GRLEN_DEF = 64;
`else
   localparam int GRLEN_DEF = 32;
`endif

   localparam int BRU_CODE_W = 4;

   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_EQZ = 4'd0;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_NEZ = 4'd1;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_EQ  = 4'd2;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_NE  = 4'd3;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_LT  = 4'd4;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_GE  = 4'd5;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_LTU = 4'd6;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_GEU = 4'd7;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_JR  = 4'd8;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_BL  = 4'd9;
   localparam logic [BRU_CODE_W-1:0] LSOC1K_BRU_B   = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FULL = 2'd1,
      ST_HOLD = 2'd2
   } bru_state_e;

endpackage

// File: rtl/bru_eval.sv
// Combinational branch evaluation: condition, resolved target, link PC and
// comparison against the front-end prediction.
module bru_eval #(
   parameter int GRLEN      = 32,
   parameter int BRU_CODE_W = 4
) (
   input  logic [BRU_CODE_W-1:0] op,
   input  logic [GRLEN-1:0]      a,
   input  logic [GRLEN-1:0]      b,
   input  logic [GRLEN-1:0]      pc,
   input  logic [GRLEN-1:0]      offset,
   input  logic                  pred_taken,
   input  logic [GRLEN-1:0]      pred_target,
   output logic                  taken,
   output logic [GRLEN-1:0]      target,
   output logic [GRLEN-1:0]      link_pc,
   output logic                  mispredict
);
   import bru_resolve_pipe_pkg::*;

   logic             is_jr;
   logic [GRLEN-1:0] seq_pc;
   logic [GRLEN-1:0] br_pc;
   logic [GRLEN-1:0] jr_pc;

   always_comb begin
      taken = 1'b0;
      is_jr = 1'b0;
      case (op)
         BRU_CODE_W'(LSOC1K_BRU_EQZ): taken = (a == '0);
         BRU_CODE_W'(LSOC1K_BRU_NEZ): taken = (a != '0);
         BRU_CODE_W'(LSOC1K_BRU_EQ):  taken = (a == b);
         BRU_CODE_W'(LSOC1K_BRU_NE):  taken = (a != b);
         BRU_CODE_W'(LSOC1K_BRU_LT):  taken = ($signed(a) <  $signed(b));
         BRU_CODE_W'(LSOC1K_BRU_GE):  taken = ($signed(a) >= $signed(b));
         BRU_CODE_W'(LSOC1K_BRU_LTU): taken = (a <  b);
         BRU_CODE_W'(LSOC1K_BRU_GEU): taken = (a >= b);
         BRU_CODE_W'(LSOC1K_BRU_JR):  begin taken = 1'b1; is_jr = 1'b1; end
         BRU_CODE_W'(LSOC1K_BRU_BL):  taken = 1'b1;
         BRU_CODE_W'(LSOC1K_BRU_B):   taken = 1'b1;
         default:                     taken = 1'b0;
      endcase

      // Sequential and branch targets are word-aligned; the JR target is not.
      seq_pc  = {pc[GRLEN-1:2] + (GRLEN-2)'(1), 2'b00};
      br_pc   = {pc[GRLEN-1:2], 2'b00} + offset;
      jr_pc   = a + offset;
      target  = is_jr ? jr_pc : (taken ? br_pc : seq_pc);
      link_pc = pc + GRLEN'(4);

      mispredict = (taken != pred_taken) || (taken && (target != pred_target));
   end

endmodule

// File: rtl/bru_resolve_pipe.sv
// Registered branch resolution stage: one-entry slot with a hold state that
// parks a misprediction until the pipeline allows the redirect.
module bru_resolve_pipe #(
   parameter int GRLEN      = 32,
   parameter int BRU_CODE_W = 4,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BRU_CODE_W-1:0] in_op,
   input  logic [GRLEN-1:0]      in_a,
   input  logic [GRLEN-1:0]      in_b,
   input  logic [GRLEN-1:0]      in_pc,
   input  logic [GRLEN-1:0]      in_offset,
   input  logic                  in_pred_taken,
   input  logic [GRLEN-1:0]      in_pred_target,
   input  logic                  cancel_allow,
   input  logic                  flush,
   output logic                  out_valid,
   output logic                  out_cancel,
   output logic [GRLEN-1:0]      out_target,
   output logic                  out_taken,
   output logic [GRLEN-1:0]      out_link_pc,
   output logic [GRLEN-1:0]      out_pc,
   output logic [CNT_W-1:0]      stat_branches,
   output logic [CNT_W-1:0]      stat_mispredicts
);
   import bru_resolve_pipe_pkg::*;

   bru_state_e       state_reg, state_next;
   logic             transfer;
   logic             slot_full;

   logic             eval_taken, eval_mispredict;
   logic [GRLEN-1:0] eval_target, eval_link_pc;

   logic             taken_reg, mispredict_reg;
   logic [GRLEN-1:0] target_reg, link_pc_reg, pc_reg;
   logic [CNT_W-1:0] branches_reg, mispredicts_reg;

   bru_eval #(
      .GRLEN      (GRLEN),
      .BRU_CODE_W (BRU_CODE_W)
   ) u_eval (
      .op          (in_op),
      .a           (in_a),
      .b           (in_b),
      .pc          (in_pc),
      .offset      (in_offset),
      .pred_taken  (in_pred_taken),
      .pred_target (in_pred_target),
      .taken       (eval_taken),
      .target      (eval_target),
      .link_pc     (eval_link_pc),
      .mispredict  (eval_mispredict)
   );

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_cancel = 1'b0;
      case (state_reg)
         ST_IDLE: in_ready = !flush;
         ST_FULL: begin
            if (!flush) begin
               if (!mispredict_reg) begin
                  out_valid = 1'b1;
                  in_ready  = 1'b1;
               end else if (cancel_allow) begin
                  out_valid  = 1'b1;
                  out_cancel = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (!flush && cancel_allow) begin
               out_valid  = 1'b1;
               out_cancel = 1'b1;
            end
         end
         default: ;
      endcase

      transfer = in_valid && in_ready;

      // A correctly predicted slot retires while the next branch loads.
      if (flush) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: state_next = transfer ? ST_FULL : ST_IDLE;
            ST_FULL: begin
               if (!mispredict_reg) state_next = transfer ? ST_FULL : ST_IDLE;
               else                 state_next = cancel_allow ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: state_next = cancel_allow ? ST_IDLE : ST_HOLD;
            default: state_next = ST_IDLE;
         endcase
      end

      // A pending cancel must never escape while reset is asserted.
      if (reset) begin
         out_valid  = 1'b0;
         out_cancel = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         taken_reg       <= 1'b0;
         mispredict_reg  <= 1'b0;
         target_reg      <= '0;
         link_pc_reg     <= '0;
         pc_reg          <= '0;
         branches_reg    <= '0;
         mispredicts_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (transfer) begin
            taken_reg      <= eval_taken;
            mispredict_reg <= eval_mispredict;
            target_reg     <= eval_target;
            link_pc_reg    <= eval_link_pc;
            pc_reg         <= in_pc;
         end
         if (out_valid)  branches_reg    <= branches_reg + CNT_W'(1);
         if (out_cancel) mispredicts_reg <= mispredicts_reg + CNT_W'(1);
      end
   end

   assign slot_full        = (state_reg != ST_IDLE);
   assign out_target       = slot_full ? target_reg  : '0;
   assign out_taken        = slot_full ? taken_reg   : 1'b0;
   assign out_link_pc      = slot_full ? link_pc_reg : '0;
   assign out_pc           = slot_full ? pc_reg      : '0;
   assign stat_branches    = branches_reg;
   assign stat_mispredicts = mispredicts_reg;

endmodule

// File: tb/tb_bru_resolve_pipe.sv
// Scoreboard bench for bru_resolve_pipe: stimulus pushes expected retirements,
// a monitor pops and compares them whenever out_valid is seen.
module tb_bru_resolve_pipe;
   import bru_resolve_pipe_pkg::*;

   localparam int GRLEN = 32;
   localparam int CNT_W = 4;

   typedef struct {
      logic        cancel;
      logic        taken;
      logic [31:0] target;
      logic [31:0] link;
      logic [31:0] pc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid, in_ready;
   logic [3:0]       in_op;
   logic [31:0]      in_a, in_b, in_pc, in_offset, in_pred_target;
   logic             in_pred_taken, cancel_allow, flush;
   logic             out_valid, out_cancel, out_taken;
   logic [31:0]      out_target, out_link_pc, out_pc;
   logic [CNT_W-1:0] stat_branches, stat_mispredicts;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   bru_resolve_pipe #(.GRLEN(GRLEN), .BRU_CODE_W(4), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_op            (in_op),
      .in_a             (in_a),
      .in_b             (in_b),
      .in_pc            (in_pc),
      .in_offset        (in_offset),
      .in_pred_taken    (in_pred_taken),
      .in_pred_target   (in_pred_target),
      .cancel_allow     (cancel_allow),
      .flush            (flush),
      .out_valid        (out_valid),
      .out_cancel       (out_cancel),
      .out_target       (out_target),
      .out_taken        (out_taken),
      .out_link_pc      (out_link_pc),
      .out_pc           (out_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
      end else begin
         $display("[TB] check %s = %0h ok", name, act);
      end
   endtask

   // Presents one branch and holds it until accepted (bounded wait).
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off,
                        input logic ptk, input logic [31:0] ptgt,
                        input bit push, input exp_t e);
      int n;
      in_op = op; in_a = a; in_b = b; in_pc = pc; in_offset = off;
      in_pred_taken = ptk; in_pred_target = ptgt; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL accept pc=%0h: in_ready stayed 0", pc);
      end else if (push) begin
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic c, input logic t, input logic [31:0] tg,
                               input logic [31:0] lk, input logic [31:0] p);
      exp_t e;
      e.cancel = c; e.taken = t; e.target = tg; e.link = lk; e.pc = p;
      return e;
   endfunction

   // Monitor: every retirement must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("[TB] FAIL retire_unexpected: got pc=%0h cancel=%0d expected no retirement",
                        out_pc, out_cancel);
            end else begin
               e = exp_q.pop_front();
               if (out_cancel !== e.cancel || out_taken !== e.taken || out_target !== e.target ||
                   out_link_pc !== e.link || out_pc !== e.pc) begin
                  fails++;
                  $display("[TB] FAIL retire pc=%0h: got c=%0d t=%0d tgt=%0h lk=%0h pc=%0h expected c=%0d t=%0d tgt=%0h lk=%0h pc=%0h",
                           e.pc, out_cancel, out_taken, out_target, out_link_pc, out_pc,
                           e.cancel, e.taken, e.target, e.link, e.pc);
               end else begin
                  $display("[TB] retire pc=%0h tgt=%0h taken=%0d cancel=%0d ok",
                           out_pc, out_target, out_taken, out_cancel);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t none;
      none = mk(0, 0, 0, 0, 0);
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_pc = '0;
      in_offset = '0; in_pred_taken = 1'b0; in_pred_target = '0;
      cancel_allow = 1'b1; flush = 1'b0;
      tick(3);
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_target", 64'(out_target), 64'd0);
      check("rst_stat_br", 64'(stat_branches), 64'd0);
      check("rst_stat_mp", 64'(stat_mispredicts), 64'd0);
      @(posedge clk); #1;

      // BEQ correctly predicted taken
      issue(LSOC1K_BRU_EQ, 32'd5, 32'd5, 32'h1000, 32'h40, 1'b1, 32'h1040, 1,
            mk(0, 1, 32'h1040, 32'h1004, 32'h1000));
      tick(2);

      // BLT signed: -1 < 1 taken, predicted not taken -> immediate cancel
      issue(LSOC1K_BRU_LT, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h10, 1'b0, 32'h0, 1,
            mk(1, 1, 32'h2010, 32'h2004, 32'h2000));
      @(negedge clk);
      check("blt_cancel", 64'(out_cancel), 64'd1);
      check("blt_ready_in_cancel", 64'(in_ready), 64'd0);
      tick(2);

      // BLTU unsigned: 0xFFFFFFFF < 1 false -> sequential target
      issue(LSOC1K_BRU_LTU, 32'hFFFF_FFFF, 32'd1, 32'h2000, 32'h10, 1'b0, 32'h0, 1,
            mk(0, 0, 32'h2004, 32'h2004, 32'h2000));
      tick(2);

      // JR with wrong predicted target, cancel withheld for 3 cycles
      cancel_allow = 1'b0;
      issue(LSOC1K_BRU_JR, 32'h2003, 32'h0, 32'h2400, 32'h4, 1'b1, 32'h2000, 1,
            mk(1, 1, 32'h2007, 32'h2404, 32'h2400));
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_out_valid", 64'(out_valid), 64'd0);
         check("hold_out_target", 64'(out_target), 64'h2007);
      end
      @(posedge clk); #1;
      cancel_allow = 1'b1;
      @(negedge clk);
      check("jr_cancel_pulse", 64'(out_cancel), 64'd1);
      check("jr_ready_in_cancel", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("jr_after_cancel_valid", 64'(out_cancel), 64'd0);
      check("stat_br_4", 64'(stat_branches), 64'd4);
      check("stat_mp_2", 64'(stat_mispredicts), 64'd2);
      @(posedge clk); #1;

      // 8 back-to-back correctly predicted taken branches
      for (int i = 0; i < 8; i++) begin
         logic [31:0] p;
         p = 32'h3000 + 32'(i) * 32'h10;
         if (i > 0) check("b2b_out_valid", 64'(out_valid), 64'd1);
         check("b2b_in_ready", 64'(in_ready), 64'd1);
         issue((i % 2 == 0) ? LSOC1K_BRU_B : LSOC1K_BRU_EQZ, 32'h0, 32'h0, p, 32'h100,
               1'b1, p + 32'h100, 1, mk(0, 1, p + 32'h100, p + 32'h4, p));
      end
      tick(2);
      check("stat_br_12", 64'(stat_branches), 64'd12);
      check("stat_mp_still_2", 64'(stat_mispredicts), 64'd2);

      // Mispredict parked in HOLD, then flush and cancel_allow together
      cancel_allow = 1'b0;
      issue(LSOC1K_BRU_NE, 32'd1, 32'd2, 32'h4000, 32'h20, 1'b0, 32'h0, 0, none);
      @(posedge clk); #1;
      flush = 1'b1;
      cancel_allow = 1'b1;
      @(negedge clk);
      check("flush_no_cancel", 64'(out_cancel), 64'd0);
      check("flush_no_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("post_flush_valid", 64'(out_valid), 64'd0);
      check("post_flush_target", 64'(out_target), 64'd0);
      check("post_flush_stat_mp", 64'(stat_mispredicts), 64'd2);
      @(posedge clk); #1;

      // Four more retirements wrap the 4-bit branch counter to 0
      issue(LSOC1K_BRU_GE, 32'hFFFF_FFFF, 32'd1, 32'h5000, 32'h80, 1'b0, 32'h0, 1,
            mk(0, 0, 32'h5004, 32'h5004, 32'h5000));
      issue(LSOC1K_BRU_GEU, 32'hFFFF_FFFF, 32'd1, 32'h5100, 32'h80, 1'b1, 32'h5180, 1,
            mk(0, 1, 32'h5180, 32'h5104, 32'h5100));
      issue(LSOC1K_BRU_NEZ, 32'h0, 32'h0, 32'h5200, 32'h80, 1'b0, 32'h0, 1,
            mk(0, 0, 32'h5204, 32'h5204, 32'h5200));
      issue(LSOC1K_BRU_NE, 32'd3, 32'd3, 32'h5300, 32'h80, 1'b0, 32'h0, 1,
            mk(0, 0, 32'h5304, 32'h5304, 32'h5300));
      tick(2);
      check("stat_br_wrap", 64'(stat_branches), 64'd0);
      check("stat_mp_wrap", 64'(stat_mispredicts), 64'd2);

      // Reset while a BL mispredict is parked in HOLD
      cancel_allow = 1'b0;
      issue(LSOC1K_BRU_BL, 32'h0, 32'h0, 32'h6000, 32'h200, 1'b0, 32'h0, 0, none);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cancel_allow = 1'b1;
      @(negedge clk);
      check("rsthold_valid", 64'(out_valid), 64'd0);
      check("rsthold_cancel", 64'(out_cancel), 64'd0);
      check("rsthold_target", 64'(out_target), 64'd0);
      check("rsthold_link", 64'(out_link_pc), 64'd0);
      check("rsthold_in_ready", 64'(in_ready), 64'd1);
      check("rsthold_stat_mp", 64'(stat_mispredicts), 64'd0);
      tick(2);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
